// File: rtl/pc_fetch_controller_if.sv
// Fetch-controller bus: instruction-memory request/ack, decode valid/stall,
// branch-decision inputs and program-counter status outputs.
interface pc_fetch_controller_if #(
    parameter int COUNT_WIDTH = 32
);
    logic                   memReq;
    logic [31:0]            memAddr;
    logic                   memAck;
    logic [31:0]            memData;
    logic                   stall;
    logic                   instrValid;
    logic [31:0]            instruction;
    logic                   branchFlag;
    logic                   unconditionalBranchFlag;
    logic                   zeroFlag;
    logic [31:0]            pcOffsetFilled;
    logic [31:0]            PC;
    logic [COUNT_WIDTH-1:0] acceptCount;

    // master: the fetch controller; slave: memory plus decode
    modport master (
        output memReq, memAddr, instrValid, instruction, PC, acceptCount,
        input  memAck, memData, stall, branchFlag, unconditionalBranchFlag,
               zeroFlag, pcOffsetFilled
    );

    modport slave (
        input  memReq, memAddr, instrValid, instruction, PC, acceptCount,
        output memAck, memData, stall, branchFlag, unconditionalBranchFlag,
               zeroFlag, pcOffsetFilled
    );
endinterface

// File: rtl/pc_fetch_controller.sv
// Program-counter owner: fetches one word per request/ack, presents it to decode,
// then applies the branch decision on accept (PC+4 or PC + offset*4).
module pc_fetch_controller #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          COUNT_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    pc_fetch_controller_if.master bus
);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 stateReg, stateNext;
    logic [31:0]            pcReg, pcNext;
    logic [31:0]            instrReg, instrNext;
    logic [COUNT_WIDTH-1:0] countReg, countNext;
    logic                   taken;
    logic [31:0]            branchTarget;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateReg <= BOOT;
            pcReg    <= RESET_PC;
            instrReg <= 32'h0;
            countReg <= '0;
        end else begin
            stateReg <= stateNext;
            pcReg    <= pcNext;
            instrReg <= instrNext;
            countReg <= countNext;
        end
    end

    // Shift drops the offset's top two bits; the add wraps modulo 2^32.
    assign taken        = (bus.zeroFlag & bus.branchFlag) | bus.unconditionalBranchFlag;
    assign branchTarget = pcReg + {bus.pcOffsetFilled[29:0], 2'b00};

    always_comb begin
        stateNext = stateReg;
        pcNext    = pcReg;
        instrNext = instrReg;
        countNext = countReg;
        case (stateReg)
            BOOT: begin
                stateNext = FETCH;
            end
            FETCH: begin
                if (bus.memAck) begin
                    instrNext = bus.memData;
                    stateNext = PRESENT;
                end
            end
            PRESENT: begin
                // Stall freezes everything; branch inputs only matter on accept.
                if (!bus.stall) begin
                    pcNext    = taken ? branchTarget : pcReg + 32'd4;
                    countNext = countReg + COUNT_ONE;
                    stateNext = FETCH;
                end
            end
            default: begin
                stateNext = BOOT;
            end
        endcase
    end

    // Outputs come from registers or the state alone, never straight from inputs.
    assign bus.memReq      = (stateReg == FETCH);
    assign bus.instrValid  = (stateReg == PRESENT);
    assign bus.memAddr     = pcReg;
    assign bus.PC          = pcReg;
    assign bus.instruction = instrReg;
    assign bus.acceptCount = countReg;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Scoreboarded bench for pc_fetch_controller: the driver pushes each acked word,
// a separate monitor pops it when decode sees it; a PC model tracks branches.
module tb_pc_fetch_controller;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pc_fetch_controller_if #(.COUNT_WIDTH(32)) bus ();

    pc_fetch_controller #(
        .RESET_PC   (32'h0000_0000),
        .COUNT_WIDTH(32)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] modelPc;
    logic [31:0] modelCount;
    logic [31:0] lastData;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Called at a falling edge while the DUT is in FETCH; returns in PRESENT.
    task automatic fetchOne(input int delay, input logic [31:0] data);
        for (int i = 0; i < delay; i++) begin
            bus.memAck  = 1'b0;
            bus.memData = $urandom;
            checkBit("wait_memReq", bus.memReq, 1'b1);
            check32("wait_memAddr", bus.memAddr, modelPc);
            checkBit("wait_instrValid", bus.instrValid, 1'b0);
            @(negedge clock);
        end
        checkBit("fetch_memReq", bus.memReq, 1'b1);
        check32("fetch_memAddr", bus.memAddr, modelPc);
        bus.memAck  = 1'b1;
        bus.memData = data;
        lastData    = data;
        expQ.push_back(exp_t'{pc: modelPc, instr: data});
        @(negedge clock);
        bus.memAck = 1'b0;
    endtask

    // Called while presenting; stalls, then accepts with the given branch inputs.
    task automatic presentOne(input int stallN, input logic b, input logic u,
                              input logic z, input logic [31:0] off);
        for (int i = 0; i < stallN; i++) begin
            bus.stall                   = 1'b1;
            bus.branchFlag              = 1'($urandom);
            bus.unconditionalBranchFlag = 1'($urandom);
            bus.zeroFlag                = 1'($urandom);
            bus.pcOffsetFilled          = $urandom;
            bus.memAck                  = 1'($urandom);
            bus.memData                 = $urandom;
            @(negedge clock);
            checkBit("stall_instrValid", bus.instrValid, 1'b1);
            checkBit("stall_memReq", bus.memReq, 1'b0);
            check32("stall_PC", bus.PC, modelPc);
            check32("stall_instruction", bus.instruction, lastData);
            check32("stall_acceptCount", bus.acceptCount, modelCount);
        end
        bus.stall                   = 1'b0;
        bus.branchFlag              = b;
        bus.unconditionalBranchFlag = u;
        bus.zeroFlag                = z;
        bus.pcOffsetFilled          = off;
        bus.memAck                  = 1'($urandom);
        if ((b && z) || u)
            modelPc = modelPc + off * 32'd4;
        else
            modelPc = modelPc + 32'd4;
        modelCount = modelCount + 32'd1;
        @(negedge clock);
        bus.memAck = 1'b0;
        bus.stall  = 1'($urandom);
        check32("accept_acceptCount", bus.acceptCount, modelCount);
        check32("accept_PC", bus.PC, modelPc);
        checkBit("accept_instrValid", bus.instrValid, 1'b0);
        checkBit("accept_memReq", bus.memReq, 1'b1);
    endtask

    // Monitor: every new presentation must match the oldest acked word.
    initial begin
        logic prevValid;
        exp_t e;
        prevValid = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prevValid = 1'b0;
            end else begin
                if (bus.instrValid && !prevValid) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected: got pc %h instr %h, expected no presentation",
                                 bus.PC, bus.instruction);
                    end else begin
                        e = expQ.pop_front();
                        check32("sb_pc", bus.PC, e.pc);
                        check32("sb_instr", bus.instruction, e.instr);
                        $display("txn pc=%h instr=%h", bus.PC, bus.instruction);
                    end
                end
                prevValid = bus.instrValid;
            end
        end
    end

    initial begin
        logic [31:0] off;
        int          tmp;
        bus.memAck                  = 1'b0;
        bus.memData                 = 32'h0;
        bus.stall                   = 1'b0;
        bus.branchFlag              = 1'b0;
        bus.unconditionalBranchFlag = 1'b0;
        bus.zeroFlag                = 1'b0;
        bus.pcOffsetFilled          = 32'h0;
        modelPc                     = 32'h0;
        modelCount                  = 32'h0;
        lastData                    = 32'h0;

        repeat (2) @(negedge clock);
        checkBit("reset_memReq", bus.memReq, 1'b0);
        checkBit("reset_instrValid", bus.instrValid, 1'b0);
        check32("reset_instruction", bus.instruction, 32'h0);
        check32("reset_acceptCount", bus.acceptCount, 32'h0);
        check32("reset_PC", bus.PC, 32'h0);
        reset = 1'b0;
        #1;
        checkBit("boot_memReq", bus.memReq, 1'b0);
        @(negedge clock);

        // Straight-line fetch with immediate ack.
        for (int i = 0; i < 3; i++) begin
            fetchOne(0, $urandom);
            presentOne(0, 1'b0, 1'b0, 1'b0, 32'h0);
        end
        check32("count_after_three", bus.acceptCount, 32'd3);
        check32("pc_after_three", bus.PC, 32'd12);

        // Long memory wait, then a stalled presentation.
        fetchOne(5, 32'hDEAD_BEEF);
        check32("deadbeef_instruction", bus.instruction, 32'hDEAD_BEEF);
        checkBit("deadbeef_valid", bus.instrValid, 1'b1);
        presentOne(4, 1'b0, 1'b0, 1'b0, 32'h0);
        check32("after_stall_pc", bus.PC, 32'd16);
        check32("after_stall_count", bus.acceptCount, 32'd4);

        // Branch arithmetic: forward jump, negative offset, not-taken conditional.
        fetchOne(0, $urandom);
        presentOne(0, 1'b0, 1'b1, 1'b0, 32'd21);
        check32("jump_to_100", bus.PC, 32'd100);
        fetchOne(1, $urandom);
        presentOne(0, 1'b1, 1'b0, 1'b1, -32'sd5);
        check32("branch_back_80", bus.PC, 32'd80);
        fetchOne(0, $urandom);
        presentOne(1, 1'b1, 1'b0, 1'b0, 32'd7);
        check32("not_taken_84", bus.PC, 32'd84);

        // Wrap-around at the top of the address space.
        fetchOne(0, $urandom);
        presentOne(0, 1'b0, 1'b1, 1'b0, (32'hFFFF_FFF8 - modelPc) >> 2);
        check32("reach_fff8", bus.PC, 32'hFFFF_FFF8);
        fetchOne(0, $urandom);
        presentOne(0, 1'b0, 1'b1, 1'b0, 32'd3);
        check32("wrap_taken_4", bus.PC, 32'd4);
        fetchOne(0, $urandom);
        presentOne(0, 1'b0, 1'b1, 1'b0, (32'hFFFF_FFFC - modelPc) >> 2);
        fetchOne(0, $urandom);
        presentOne(0, 1'b0, 1'b0, 1'b1, $urandom);
        check32("wrap_not_taken_0", bus.PC, 32'd0);

        // Branch-to-self re-fetches the same address.
        fetchOne(0, $urandom);
        presentOne(0, 1'b1, 1'b0, 1'b1, 32'd0);
        check32("self_loop_pc", bus.PC, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                off = $urandom;
            end else begin
                tmp = int'($urandom_range(0, 40)) - 20;
                off = 32'(tmp);
            end
            fetchOne(int'($urandom_range(0, 3)), $urandom);
            presentOne(int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom),
                       1'($urandom), off);
        end

        // Asynchronous reset between edges while requesting.
        checkBit("pre_reset_memReq", bus.memReq, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        checkBit("async_memReq", bus.memReq, 1'b0);
        checkBit("async_instrValid", bus.instrValid, 1'b0);
        check32("async_acceptCount", bus.acceptCount, 32'h0);
        check32("async_PC", bus.PC, 32'h0);
        check32("async_instruction", bus.instruction, 32'h0);
        modelPc    = 32'h0;
        modelCount = 32'h0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkBit("reboot_memReq", bus.memReq, 1'b0);
        @(negedge clock);
        checkBit("restart_memReq", bus.memReq, 1'b1);
        check32("restart_memAddr", bus.memAddr, 32'h0);
        fetchOne(0, $urandom);
        presentOne(0, 1'b0, 1'b0, 1'b0, 32'h0);
        check32("restart_count", bus.acceptCount, 32'd1);

        @(negedge clock);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
